// File: rtl/counter_cmd_seq.sv
// Command sequencer driving a downstream up-counter: accepts LOAD/RUN commands
// and turns them into load strobes, enable windows and a completion pulse.
module counter_cmd_seq #(
  parameter int IDATA_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [IDATA_WIDTH-1:0] cmd_data,
  input  logic                   hold,
  input  logic                   abort,
  output logic                   load,
  output logic                   enable,
  output logic [IDATA_WIDTH-1:0] data_in,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0]             OP_LOAD = 2'b01;
  localparam logic [1:0]             OP_RUN  = 2'b10;
  localparam logic [IDATA_WIDTH-1:0] ONE     = {{(IDATA_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state;
  logic [IDATA_WIDTH-1:0] remaining;

  // Strobes decode straight from state so an asynchronous reset drops them at once;
  // abort masks them in the same cycle it is raised.
  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign load      = (state == S_LOAD) && !abort;
  assign enable    = (state == S_RUN) && !hold && !abort;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      remaining <= '0;
      data_in   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_LOAD: begin
                data_in <= cmd_data;
                state   <= S_LOAD;
              end
              OP_RUN: begin
                if (cmd_data == '0) begin
                  state <= S_DONE;
                end else begin
                  remaining <= cmd_data;
                  state     <= S_RUN;
                end
              end
              default: state <= S_IDLE;
            endcase
          end
        end
        S_LOAD: state <= abort ? S_IDLE : S_DONE;
        S_RUN: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (!hold) begin
            // Count is consumed on enabled cycles only; leaving at 1 gives exactly N enables.
            remaining <= remaining - ONE;
            if (remaining == ONE) state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_cmd_seq.sv
// Directed bench for counter_cmd_seq: linear command sequence with hand-computed
// output vectors {load, enable, done, busy, cmd_ready} checked mid-cycle.
module tb_counter_cmd_seq;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_data;
  logic        hold;
  logic        abort;
  logic        load;
  logic        enable;
  logic [15:0] data_in;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  // {load, enable, done, busy, cmd_ready}
  localparam logic [4:0] V_IDLE = 5'b00001;
  localparam logic [4:0] V_LD   = 5'b10010;
  localparam logic [4:0] V_EN   = 5'b01010;
  localparam logic [4:0] V_BSY  = 5'b00010;
  localparam logic [4:0] V_DN   = 5'b00110;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_LD  = 2'b01;
  localparam logic [1:0] OP_RUN = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  counter_cmd_seq #(.IDATA_WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .hold      (hold),
    .abort     (abort),
    .load      (load),
    .enable    (enable),
    .data_in   (data_in),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic exp5(input string tag, input logic [4:0] e);
    logic [4:0] o;
    o = {load, enable, done, busy, cmd_ready};
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s {ld,en,dn,bsy,rdy} observed=%b expected=%b", tag, o, e);
    end
    checks++;
    assert (!(load && enable)) else begin
      errors++;
      $error("FAIL %s_excl load=%b enable=%b expected not both high", tag, load, enable);
    end
  endtask

  task automatic expd(input string tag, input logic [15:0] e);
    checks++;
    assert (data_in === e) else begin
      errors++;
      $error("FAIL %s data_in observed=%h expected=%h", tag, data_in, e);
    end
  endtask

  task automatic expn(input string tag, input int o, input int e);
    checks++;
    assert (o == e) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Present a command in an IDLE cycle, take the handshake edge, clear the inputs.
  task automatic issue(input logic [1:0] op, input logic [15:0] d, input logic ab);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    abort     = ab;
    #1;
    exp5("issue_ready", V_IDLE);
    cyc();
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    cmd_data  = '0;
    abort     = 1'b0;
  endtask

  initial begin
    logic [5:0] hold_pat;
    logic [5:0] en_pat;
    int         cnt;

    // Command held during reset must be ignored, then taken on the first edge after release
    reset     = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = OP_LD;
    cmd_data  = 16'h1234;
    hold      = 1'b0;
    abort     = 1'b0;
    #3;
    exp5("reset_state", V_IDLE);
    expd("reset_data", 16'h0000);
    #9 reset = 1'b1;
    cyc();
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    cmd_data  = '0;
    #1 exp5("load_strobe", V_LD);
    expd("load_data", 16'h1234);
    cyc(); #1 exp5("load_done", V_DN);
    cyc(); #1 exp5("load_idle", V_IDLE);
    expd("load_data_held", 16'h1234);

    // RUN 5 without hold
    issue(OP_RUN, 16'd5, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1 exp5($sformatf("run5_en%0d", i), V_EN);
      cyc();
    end
    #1 exp5("run5_done", V_DN);
    cyc(); #1 exp5("run5_idle", V_IDLE);

    // RUN 4 with hold on cycles 2-3: enable 1,0,0,1,1,1
    hold_pat = 6'b000110;
    en_pat   = 6'b111001;
    issue(OP_RUN, 16'd4, 1'b0);
    for (int i = 0; i < 6; i++) begin
      hold = hold_pat[i];
      #1 exp5($sformatf("run4h_c%0d", i), en_pat[i] ? V_EN : V_BSY);
      cyc();
    end
    hold = 1'b0;
    #1 exp5("run4h_done", V_DN);
    cyc(); #1 exp5("run4h_idle", V_IDLE);

    // RUN 0, then NOP and reserved opcode
    issue(OP_RUN, 16'd0, 1'b0);
    #1 exp5("run0_done", V_DN);
    cyc(); #1 exp5("run0_idle", V_IDLE);
    issue(OP_NOP, 16'h7777, 1'b0);
    #1 exp5("nop_idle", V_IDLE);
    expd("nop_data", 16'h1234);
    cyc();
    issue(OP_RSV, 16'h7777, 1'b0);
    #1 exp5("rsv_idle", V_IDLE);

    // RUN 10 aborted on third enable cycle
    issue(OP_RUN, 16'd10, 1'b0);
    #1 exp5("abrt_en1", V_EN);
    cyc(); #1 exp5("abrt_en2", V_EN);
    cyc();
    abort = 1'b1;
    #1 exp5("abrt_cycle", V_BSY);
    cyc();
    abort = 1'b0;
    #1 exp5("abrt_idle", V_IDLE);

    // Abort alongside a LOAD handshake in IDLE is ignored
    issue(OP_LD, 16'hBEEF, 1'b1);
    #1 exp5("abld_strobe", V_LD);
    expd("abld_data", 16'hBEEF);
    cyc(); #1 exp5("abld_done", V_DN);
    cyc(); #1 exp5("abld_idle", V_IDLE);

    // Abort in LOAD: strobe suppressed, no done
    issue(OP_LD, 16'h5555, 1'b0);
    abort = 1'b1;
    #1 exp5("abload_cycle", V_BSY);
    cyc();
    abort = 1'b0;
    #1 exp5("abload_idle", V_IDLE);
    expd("abload_data", 16'h5555);

    // Abort beats completion on the last RUN cycle
    issue(OP_RUN, 16'd1, 1'b0);
    abort = 1'b1;
    #1 exp5("ablast_cycle", V_BSY);
    cyc();
    abort = 1'b0;
    #1 exp5("ablast_idle", V_IDLE);

    // Abort in DONE is ignored
    issue(OP_RUN, 16'd0, 1'b0);
    abort = 1'b1;
    #1 exp5("abdone_pulse", V_DN);
    cyc();
    abort = 1'b0;
    #1 exp5("abdone_idle", V_IDLE);

    // Asynchronous reset in the fourth cycle of RUN 8
    issue(OP_RUN, 16'd8, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1 exp5($sformatf("rst8_en%0d", i), V_EN);
      cyc();
    end
    #1 exp5("rst8_en3", V_EN);
    reset = 1'b0;
    #1 exp5("rst8_async", V_IDLE);
    expd("rst8_data", 16'h0000);
    cyc(); #1 exp5("rst8_held", V_IDLE);
    reset = 1'b1;
    issue(OP_RUN, 16'd2, 1'b0);
    #1 exp5("run2_en0", V_EN);
    cyc(); #1 exp5("run2_en1", V_EN);
    cyc(); #1 exp5("run2_done", V_DN);
    cyc(); #1 exp5("run2_idle", V_IDLE);

    // All-ones count runs to completion without wrapping
    issue(OP_RUN, 16'hFFFF, 1'b0);
    cnt = 0;
    for (int i = 0; i < 70000; i++) begin
      #1;
      if (done) break;
      if (enable) cnt++;
      cyc();
    end
    expn("runmax_enables", cnt, 65535);
    exp5("runmax_done", V_DN);
    cyc(); #1 exp5("runmax_idle", V_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_cmd_seq.md
COUNTER_CMD_SEQ -- requirements
Module: counter_cmd_seq

Interface
REQ-001 Parameter IDATA_WIDTH, default 16, SHALL set the width of cmd_data and data_in.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; one clock, and reset is asynchronous and active-low.
REQ-004 cmd_valid  input  1  command present on cmd_op/cmd_data.
REQ-005 cmd_ready  output  1  block can accept a command this cycle.
REQ-006 cmd_op  input  2  00 NOP, 01 LOAD, 10 RUN, 11 reserved (treated as NOP).
REQ-007 cmd_data  input  IDATA_WIDTH  LOAD value, or RUN cycle count.
REQ-008 hold  input  1  pause RUN: freezes enable and remaining count.
REQ-009 abort  input  1  cancel in-flight LOAD/RUN.
REQ-010 load  output  1  load strobe to downstream counter.
REQ-011 enable  output  1  count-up enable to downstream counter.
REQ-012 data_in  output  IDATA_WIDTH  load value to downstream counter.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 done  output  1  one-cycle completion pulse.

Function
REQ-015 States SHALL be IDLE, LOAD, RUN, DONE; cmd_ready SHALL equal (state == IDLE).
REQ-016 Handshake SHALL occur on a rising edge where cmd_valid && cmd_ready; cmd_op/cmd_data sampled only then.
REQ-017 IDLE + accepted LOAD: data_in <= cmd_data, next state LOAD.
REQ-018 IDLE + accepted RUN, cmd_data != 0: remaining <= cmd_data, next state RUN.
REQ-019 IDLE + accepted RUN, cmd_data == 0: next state DONE; enable never asserted.
REQ-020 IDLE + accepted NOP/reserved: stay IDLE; no load, enable or done.
REQ-021 LOAD: load = 1 for exactly one cycle, then DONE; data_in stable from acceptance until next accepted LOAD.
REQ-022 RUN: enable = !hold && !abort (combinational from state, hold, abort); remaining decrements by 1 on each cycle enable == 1.
REQ-023 RUN with enable == 1 and remaining == 1: next state DONE; total enable-high cycles SHALL equal the accepted count exactly.
REQ-024 RUN with hold == 1: stay RUN, remaining unchanged, enable = 0; no hold timeout.
REQ-025 DONE: done = 1 for one cycle, then IDLE; load and enable = 0.
REQ-026 abort in LOAD or RUN: next state IDLE, no done pulse; load and enable forced 0 in the abort cycle; abort has priority over hold and completion.
REQ-027 abort in IDLE or DONE: ignored; a command handshaking in IDLE that cycle is accepted normally.
REQ-028 Latency: handshake at edge N -> LOAD strobe in cycle N+1, done in cycle N+2; RUN k (no hold) -> enable cycles N+1..N+k, done in cycle N+k+1.
REQ-029 remaining SHALL be IDATA_WIDTH bits; RUN count of all-ones SHALL be honoured without wrap.
REQ-030 load and enable SHALL never be high in the same cycle.

Reset
REQ-031 reset low SHALL immediately force state IDLE, remaining 0, data_in 0, load 0, enable 0, done 0, busy 0; cmd_ready 1 after release.
REQ-032 reset asserted mid-LOAD or mid-RUN SHALL drop all strobes asynchronously with no done pulse.
REQ-033 First handshake possible on the first rising edge after reset deassertion.

Verification
REQ-034 LOAD 0x1234 -> one cycle load = 1 with data_in = 0x1234, done next cycle, busy 2 cycles.
REQ-035 RUN 5, hold low -> enable high exactly 5 consecutive cycles, done on cycle 6, cmd_ready low throughout.
REQ-036 RUN 4 with hold high on enable cycles 2-3 -> enable pattern 1,0,0,1,1,1; done after 4th enable.
REQ-037 RUN 0 -> no enable, done one cycle after handshake; NOP -> no outputs, cmd_ready stays 1.
REQ-038 RUN 10, abort on 3rd enable cycle -> exactly 2 enables, no done, IDLE next cycle; abort asserted with a LOAD in IDLE -> LOAD still executes.
REQ-039 reset low during RUN 8 at cycle 4 -> enable 0 immediately, data_in 0, busy 0; new RUN 2 after release completes normally.
